// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the pipeline hazard/forwarding controller.
// Contents: scoreboard entry struct, forward-select encoding, hazard case enum.
// Ports: none (package).
package hazard_scoreboard_pkg;

  // Register address width carried in each scoreboard entry.
  localparam int SB_REG_AW = 5;

  // fwd_sel encoding: 0 takes the RF/ID operand, k takes the stage-k result.
  localparam logic [2:0] FWD_RF = 3'd0;

  // One in-flight instruction: valid, destination, writes RF, is a load.
  typedef struct packed {
    logic                 v;
    logic [SB_REG_AW-1:0] rd;
    logic                 wr;
    logic                 ld;
  } sb_entry_t;

  // Case selected this cycle; exported for debug visibility.
  typedef enum logic [1:0] {
    HZ_NORMAL   = 2'd0,
    HZ_LOADUSE  = 2'd1,
    HZ_REDIRECT = 2'd2,
    HZ_FREEZE   = 2'd3
  } hz_state_e;

  // Empty slot shifted in behind a stall or a flush.
  function automatic sb_entry_t sb_bubble();
    return '0;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle between the pipeline datapath and the hazard scoreboard.
// master: datapath (drives ID instruction, stall and redirect; reads controls).
// slave: scoreboard (reads ID/stall inputs; drives enables, forward selects, counter, debug).
interface hazard_scoreboard_if
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int NUM_SRC    = 3,
  parameter int REG_AW     = SB_REG_AW,
  parameter int CNT_W      = 32
);
  // Instruction in ID and pipeline events
  logic                      id_valid;
  logic [NUM_SRC*REG_AW-1:0] id_src;
  logic [NUM_SRC-1:0]        id_src_used;
  logic [REG_AW-1:0]         id_rd;
  logic                      id_regwrite;
  logic                      id_is_load;
  logic                      icache_stall;
  logic                      dcache_stall;
  logic                      redirect;
  // Pipeline controls
  logic                      pc_en;
  logic                      ifid_en;
  logic                      ifid_flush;
  logic                      idex_bubble;
  logic                      pipe_freeze;
  logic [NUM_SRC*3-1:0]      fwd_sel;
  logic [CNT_W-1:0]          stall_cycles;
  // Debug: active case and per-stage valid bits (bit k-1 = stage k)
  hz_state_e                 hz_state;
  logic [NUM_STAGES-1:0]     sb_v;

  modport master (
    output id_valid, id_src, id_src_used, id_rd, id_regwrite, id_is_load,
           icache_stall, dcache_stall, redirect,
    input  pc_en, ifid_en, ifid_flush, idex_bubble, pipe_freeze, fwd_sel,
           stall_cycles, hz_state, sb_v
  );

  modport slave (
    input  id_valid, id_src, id_src_used, id_rd, id_regwrite, id_is_load,
           icache_stall, dcache_stall, redirect,
    output pc_en, ifid_en, ifid_flush, idex_bubble, pipe_freeze, fwd_sel,
           stall_cycles, hz_state, sb_v
  );

endinterface

// File: rtl/hazard_scoreboard_fwd_match.sv
// Forward/load-use match for one source operand against the scoreboard.
// Ports: sb_i (stages NUM_STAGES..1), src_i address, chk_i (valid and operand read);
//        fwd_sel_o (0 = RF, k = stage k), hazard_o (youngest match is a not-yet-ready load).
module fwd_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int LOAD_LAT   = 2
) (
  input  sb_entry_t [NUM_STAGES:1] sb_i,
  input  logic [SB_REG_AW-1:0]     src_i,
  input  logic                     chk_i,
  output logic [2:0]               fwd_sel_o,
  output logic                     hazard_o
);

  // Walk oldest to youngest so the lowest-k match is the last to write and wins;
  // a younger writer of the same register shadows any older one.
  always_comb begin
    fwd_sel_o = FWD_RF;
    hazard_o  = 1'b0;
    for (int k = NUM_STAGES; k >= 1; k--) begin
      if (chk_i && sb_i[k].v && sb_i[k].wr &&
          (sb_i[k].rd != '0) && (sb_i[k].rd == src_i)) begin
        fwd_sel_o = 3'(k);
        hazard_o  = sb_i[k].ld && (k < LOAD_LAT);
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller: scoreboard of in-flight destinations EX..WB,
// stall/bubble/flush/freeze decode, per-source forward selects, stall-cycle counter.
// Ports: clk, reset (async active-low), bus (slave side of hazard_scoreboard_if).
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_STAGES  = 3,
  parameter int NUM_SRC     = 3,
  parameter int REG_AW      = SB_REG_AW,
  parameter int LOAD_LAT    = 2,
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                reset,
  hazard_scoreboard_if.slave  bus
);

  sb_entry_t [NUM_STAGES:1] sb_q, sb_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic [NUM_SRC*3-1:0]     fwd_sel_w;
  logic [NUM_SRC-1:0]       hazard_w;
  hz_state_e                st;
  logic                     pc_en_c, ifid_en_c, ifid_flush_c, idex_bubble_c, pipe_freeze_c;

  // Per-source match; id_valid gating makes an empty ID slot report nothing.
  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    fwd_match #(
      .NUM_STAGES (NUM_STAGES),
      .LOAD_LAT   (LOAD_LAT)
    ) u_fwd_match (
      .sb_i      (sb_q),
      .src_i     (bus.id_src[s*REG_AW +: REG_AW]),
      .chk_i     (bus.id_valid && bus.id_src_used[s]),
      .fwd_sel_o (fwd_sel_w[s*3 +: 3]),
      .hazard_o  (hazard_w[s])
    );
  end

  // Case priority: freeze, redirect, load-use, normal. Redirect beats load-use
  // because the stalled instruction is being flushed anyway.
  always_comb begin
    if (bus.icache_stall || bus.dcache_stall) begin
      st = HZ_FREEZE;
    end else if (bus.redirect) begin
      st = HZ_REDIRECT;
    end else if (bus.id_valid && (|hazard_w)) begin
      st = HZ_LOADUSE;
    end else begin
      st = HZ_NORMAL;
    end
  end

  always_comb begin
    pc_en_c       = 1'b1;
    ifid_en_c     = 1'b1;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;
    pipe_freeze_c = 1'b0;
    case (st)
      HZ_FREEZE: begin
        pc_en_c       = 1'b0;
        ifid_en_c     = 1'b0;
        pipe_freeze_c = 1'b1;
      end
      HZ_REDIRECT: begin
        ifid_flush_c  = 1'b1;
        idex_bubble_c = 1'b1;
      end
      HZ_LOADUSE: begin
        pc_en_c       = 1'b0;
        ifid_en_c     = 1'b0;
        idex_bubble_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs are forced to their idle values while reset is held so the
  // pipeline sees a clean state immediately, not only after the next edge.
  always_comb begin
    bus.pc_en        = 1'b1;
    bus.ifid_en      = 1'b1;
    bus.ifid_flush   = 1'b0;
    bus.idex_bubble  = 1'b0;
    bus.pipe_freeze  = 1'b0;
    bus.fwd_sel      = '0;
    bus.hz_state     = HZ_NORMAL;
    if (reset) begin
      bus.pc_en       = pc_en_c;
      bus.ifid_en     = ifid_en_c;
      bus.ifid_flush  = ifid_flush_c;
      bus.idex_bubble = idex_bubble_c;
      bus.pipe_freeze = pipe_freeze_c;
      bus.fwd_sel     = fwd_sel_w;
      bus.hz_state    = st;
    end
  end

  // Scoreboard next state. On redirect the current stages 1..FLUSH_DEPTH hold
  // wrong-path work, so they are killed as they move down one stage.
  always_comb begin
    sb_d = sb_q;
    if (st != HZ_FREEZE) begin
      for (int k = 1; k < NUM_STAGES; k++) begin
        sb_d[k+1] = sb_q[k];
        if ((st == HZ_REDIRECT) && (k <= FLUSH_DEPTH)) begin
          sb_d[k+1].v = 1'b0;
        end
      end
      if (st == HZ_NORMAL) begin
        sb_d[1] = '{v: bus.id_valid, rd: bus.id_rd, wr: bus.id_regwrite, ld: bus.id_is_load};
      end else begin
        sb_d[1] = sb_bubble();
      end
    end
  end

  // Saturating count of cycles in which the PC is held.
  always_comb begin
    cnt_d = cnt_q;
    if (!pc_en_c && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb_q  <= '0;
      cnt_q <= '0;
    end else begin
      sb_q  <= sb_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.stall_cycles = cnt_q;

  always_comb begin
    bus.sb_v = '0;
    for (int k = 1; k <= NUM_STAGES; k++) begin
      bus.sb_v[k-1] = sb_q[k].v;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with default parameters (3 stages, 3 sources).
// Covers reset values, back-to-back forwarding, load-use, redirect, freeze, r0/unused sources, async reset.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;

  hazard_scoreboard_if bus ();

  hazard_scoreboard dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Present an instruction in ID; sources packed {src2, src1, src0}.
  task automatic set_id(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                        input logic [2:0] used, input logic [4:0] rd,
                        input logic wr, input logic ld);
    bus.id_valid    = v;
    bus.id_src      = {5'd0, s1, s0};
    bus.id_src_used = used;
    bus.id_rd       = rd;
    bus.id_regwrite = wr;
    bus.id_is_load  = ld;
    #1;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 5'd0, 3'b000, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 3; i++) tick();
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    reset  = 1'b0;
    bus.icache_stall = 1'b0;
    bus.dcache_stall = 1'b0;
    bus.redirect     = 1'b0;
    idle();

    // Reset values
    #3;
    chk("rst_pc_en",   32'(bus.pc_en), 32'd1);
    chk("rst_ifid_en", 32'(bus.ifid_en), 32'd1);
    chk("rst_flush",   32'(bus.ifid_flush), 32'd0);
    chk("rst_bubble",  32'(bus.idex_bubble), 32'd0);
    chk("rst_freeze",  32'(bus.pipe_freeze), 32'd0);
    chk("rst_fwd",     32'(bus.fwd_sel), 32'd0);
    chk("rst_cnt",     bus.stall_cycles, 32'd0);
    chk("rst_sbv",     32'(bus.sb_v), 32'd0);
    #9 reset = 1'b1;
    tick();

    // Forwarding: ADD r5 ; ADD r6,r5,r5 ; use r5 one cycle later
    set_id(1'b1, 5'd1, 5'd2, 3'b011, 5'd5, 1'b1, 1'b0);
    chk("fw_first_fwd", 32'(bus.fwd_sel), 32'd0);
    tick();
    set_id(1'b1, 5'd5, 5'd5, 3'b011, 5'd6, 1'b1, 1'b0);
    chk("fw_b2b_fwd",   32'(bus.fwd_sel), 32'h009);
    chk("fw_b2b_pc_en", 32'(bus.pc_en), 32'd1);
    chk("fw_b2b_bub",   32'(bus.idex_bubble), 32'd0);
    tick();
    set_id(1'b1, 5'd5, 5'd0, 3'b011, 5'd9, 1'b1, 1'b0);
    chk("fw_mem_fwd",   32'(bus.fwd_sel), 32'h002);
    chk("fw_cnt",       bus.stall_cycles, 32'd0);
    tick();
    drain();
    chk("fw_drained",   32'(bus.sb_v), 32'd0);

    // Load-use: LW r7 ; ADD r8,r7,r1
    set_id(1'b1, 5'd2, 5'd0, 3'b001, 5'd7, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd7, 5'd1, 3'b011, 5'd8, 1'b1, 1'b0);
    chk("lu_pc_en",  32'(bus.pc_en), 32'd0);
    chk("lu_ifid",   32'(bus.ifid_en), 32'd0);
    chk("lu_bubble", 32'(bus.idex_bubble), 32'd1);
    chk("lu_state",  32'(bus.hz_state), 32'(HZ_LOADUSE));
    tick();
    chk("lu_after_pc_en",  32'(bus.pc_en), 32'd1);
    chk("lu_after_bubble", 32'(bus.idex_bubble), 32'd0);
    chk("lu_after_fwd",    32'(bus.fwd_sel), 32'h002);
    chk("lu_cnt",          bus.stall_cycles, 32'd1);
    tick();
    drain();

    // Redirect with stages 1,2 valid
    set_id(1'b1, 5'd1, 5'd0, 3'b001, 5'd10, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd1, 5'd0, 3'b001, 5'd11, 1'b1, 1'b0);
    tick();
    chk("rd_sbv_before", 32'(bus.sb_v), 32'b011);
    set_id(1'b1, 5'd10, 5'd0, 3'b001, 5'd12, 1'b1, 1'b0);
    bus.redirect = 1'b1;
    #1;
    chk("rd_flush",  32'(bus.ifid_flush), 32'd1);
    chk("rd_bubble", 32'(bus.idex_bubble), 32'd1);
    chk("rd_pc_en",  32'(bus.pc_en), 32'd1);
    tick();
    bus.redirect = 1'b0;
    set_id(1'b1, 5'd11, 5'd10, 3'b011, 5'd1, 1'b1, 1'b0);
    chk("rd_sbv_after", 32'(bus.sb_v), 32'b000);
    chk("rd_fwd_killed", 32'(bus.fwd_sel), 32'd0);
    chk("rd_cnt", bus.stall_cycles, 32'd1);
    drain();

    // Load-use and redirect together: redirect wins, no stall
    set_id(1'b1, 5'd2, 5'd0, 3'b001, 5'd7, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd7, 5'd0, 3'b001, 5'd8, 1'b1, 1'b0);
    bus.redirect = 1'b1;
    #1;
    chk("lurd_state", 32'(bus.hz_state), 32'(HZ_REDIRECT));
    chk("lurd_pc_en", 32'(bus.pc_en), 32'd1);
    tick();
    bus.redirect = 1'b0;
    drain();
    chk("lurd_cnt", bus.stall_cycles, 32'd1);

    // Freeze for 4 cycles during a load-use, then the bubble
    set_id(1'b1, 5'd2, 5'd0, 3'b001, 5'd7, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd7, 5'd1, 3'b011, 5'd8, 1'b1, 1'b0);
    bus.dcache_stall = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("fz_freeze", 32'(bus.pipe_freeze), 32'd1);
      chk("fz_pc_en",  32'(bus.pc_en), 32'd0);
      chk("fz_sbv",    32'(bus.sb_v), 32'b001);
      tick();
    end
    bus.dcache_stall = 1'b0;
    #1;
    chk("fz_lu_freeze", 32'(bus.pipe_freeze), 32'd0);
    chk("fz_lu_bubble", 32'(bus.idex_bubble), 32'd1);
    chk("fz_lu_pc_en",  32'(bus.pc_en), 32'd0);
    tick();
    chk("fz_after_fwd", 32'(bus.fwd_sel), 32'h002);
    // one stall cycle from the earlier load-use plus 4 frozen + 1 bubble
    chk("fz_cnt", bus.stall_cycles, 32'd6);
    tick();
    drain();

    // r0 is never forwarded (even from a load); unused rb ignored
    set_id(1'b1, 5'd2, 5'd0, 3'b001, 5'd0, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 3'b011, 5'd13, 1'b1, 1'b1);
    chk("r0_fwd",   32'(bus.fwd_sel), 32'd0);
    chk("r0_pc_en", 32'(bus.pc_en), 32'd1);
    tick();
    set_id(1'b1, 5'd2, 5'd13, 3'b001, 5'd14, 1'b1, 1'b0);
    chk("unused_fwd",   32'(bus.fwd_sel), 32'd0);
    chk("unused_pc_en", 32'(bus.pc_en), 32'd1);
    set_id(1'b1, 5'd2, 5'd13, 3'b011, 5'd14, 1'b1, 1'b0);
    chk("used_fwd",   32'(bus.fwd_sel), 32'h008);
    chk("used_pc_en", 32'(bus.pc_en), 32'd0);
    set_id(1'b0, 5'd2, 5'd13, 3'b011, 5'd14, 1'b1, 1'b0);
    chk("novalid_fwd",   32'(bus.fwd_sel), 32'd0);
    chk("novalid_pc_en", 32'(bus.pc_en), 32'd1);
    drain();

    // Async reset in the middle of a load-use stall
    set_id(1'b1, 5'd2, 5'd0, 3'b001, 5'd7, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd7, 5'd0, 3'b001, 5'd8, 1'b1, 1'b0);
    chk("ar_pre_pc_en", 32'(bus.pc_en), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("ar_pc_en",  32'(bus.pc_en), 32'd1);
    chk("ar_ifid",   32'(bus.ifid_en), 32'd1);
    chk("ar_bubble", 32'(bus.idex_bubble), 32'd0);
    chk("ar_fwd",    32'(bus.fwd_sel), 32'd0);
    chk("ar_cnt",    bus.stall_cycles, 32'd0);
    chk("ar_sbv",    32'(bus.sb_v), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("ar_rel_state", 32'(bus.hz_state), 32'(HZ_NORMAL));
    tick();
    chk("ar_next_cnt", bus.stall_cycles, 32'd0);
    chk("ar_next_sbv", 32'(bus.sb_v), 32'b001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
